// File: rtl/io_ctrl.sv
// IO sequencer for IN/OUT instructions: stalls the pipeline while a valid/ready
// transfer with an external device is pending, with an optional wait-state timeout.
module io_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_req,
  input  logic        out_req,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        rdata_valid,
  output logic        stall,
  input  logic [31:0] ext_in_data,
  input  logic        ext_in_valid,
  output logic        ext_in_ready,
  output logic [31:0] ext_out_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready,
  output logic [31:0] last_out,
  output logic        io_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_WAIT  = 2'd1,
    OUT_WAIT = 2'd2,
    COMPLETE = 2'd3
  } state_e;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic        op_in_q, op_in_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        ext_in_ready_q, ext_in_ready_d;
  logic [31:0] ext_out_data_q, ext_out_data_d;
  logic        ext_out_valid_q, ext_out_valid_d;
  logic [31:0] last_out_q, last_out_d;
  logic        io_error_q, io_error_d;
  logic        timeout_hit;
  logic [CNT_W-1:0] counter_inc;

  assign timeout_hit = TIMEOUT_EN && (counter_q == TIMEOUT_LAST);
  // The counter saturates so a disabled timeout never wraps back to zero.
  assign counter_inc = (counter_q == {CNT_W{1'b1}}) ? counter_q : counter_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    op_in_d        = op_in_q;
    cpu_rdata_d    = cpu_rdata_q;
    ext_out_data_d = ext_out_data_q;
    last_out_d     = last_out_q;
    io_error_d     = io_error_q;

    case (state_q)
      IDLE: begin
        if (in_req) begin
          state_d   = IN_WAIT;
          counter_d = '0;
          op_in_d   = 1'b1;
        end else if (out_req) begin
          state_d        = OUT_WAIT;
          counter_d      = '0;
          op_in_d        = 1'b0;
          ext_out_data_d = cpu_wdata;
        end
      end
      IN_WAIT: begin
        if (ext_in_valid) begin
          cpu_rdata_d = ext_in_data;
          state_d     = COMPLETE;
        end else if (timeout_hit) begin
          cpu_rdata_d = '0;
          io_error_d  = 1'b1;
          state_d     = COMPLETE;
        end else begin
          counter_d = counter_inc;
        end
      end
      OUT_WAIT: begin
        if (ext_out_ready) begin
          last_out_d = ext_out_data_q;
          state_d    = COMPLETE;
        end else if (timeout_hit) begin
          io_error_d = 1'b1;
          state_d    = COMPLETE;
        end else begin
          counter_d = counter_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake strobes are decoded from the next state so they are registered.
    ext_in_ready_d  = (state_d == IN_WAIT);
    ext_out_valid_d = (state_d == OUT_WAIT);
    rdata_valid_d   = (state_d == COMPLETE) && op_in_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      counter_q       <= '0;
      op_in_q         <= 1'b0;
      cpu_rdata_q     <= '0;
      rdata_valid_q   <= 1'b0;
      ext_in_ready_q  <= 1'b0;
      ext_out_data_q  <= '0;
      ext_out_valid_q <= 1'b0;
      last_out_q      <= '0;
      io_error_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      op_in_q         <= op_in_d;
      cpu_rdata_q     <= cpu_rdata_d;
      rdata_valid_q   <= rdata_valid_d;
      ext_in_ready_q  <= ext_in_ready_d;
      ext_out_data_q  <= ext_out_data_d;
      ext_out_valid_q <= ext_out_valid_d;
      last_out_q      <= last_out_d;
      io_error_q      <= io_error_d;
    end
  end

  assign stall = !reset &&
                 (((state_q == IDLE) && (in_req || out_req)) ||
                  (state_q == IN_WAIT) || (state_q == OUT_WAIT));

  assign cpu_rdata     = cpu_rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign ext_in_ready  = ext_in_ready_q;
  assign ext_out_data  = ext_out_data_q;
  assign ext_out_valid = ext_out_valid_q;
  assign last_out      = last_out_q;
  assign io_error      = io_error_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: directed scenarios plus randomized transfers
// checked against a transfer-level model of expected results.
module tb_io_ctrl;

  localparam int T      = 8;
  localparam int NO_HS  = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_req = 1'b0;
  logic        out_req = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        rdata_valid;
  logic        stall;
  logic [31:0] ext_in_data = '0;
  logic        ext_in_valid = 1'b0;
  logic        ext_in_ready;
  logic [31:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready = 1'b0;
  logic [31:0] last_out;
  logic        io_error;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_last  = '0;
  logic        exp_err   = 1'b0;

  io_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rdata_valid(rdata_valid),
    .stall(stall), .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid),
    .ext_in_ready(ext_in_ready), .ext_out_data(ext_out_data),
    .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .last_out(last_out), .io_error(io_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One IN/OUT instruction; hs is the wait cycle (1-based) carrying the device handshake.
  task automatic applyStimulus(input bit is_in, input bit both, input logic [31:0] data, input int hs);
    int done_c;
    bit timed_out;
    done_c    = (hs < T) ? hs : T;
    timed_out = (hs > T);

    @(posedge clock); #1;
    in_req        = is_in | both;
    out_req       = ~is_in | both;
    cpu_wdata     = data;
    ext_in_valid  = 1'b0;
    ext_out_ready = 1'b0;
    #1;
    checkOutput("req_stall", stall, 1);
    checkOutput("req_ready", ext_in_ready, 0);
    checkOutput("req_valid", ext_out_valid, 0);
    checkOutput("req_rvalid", rdata_valid, 0);

    for (int c = 1; c <= done_c; c++) begin
      @(posedge clock); #1;
      cpu_wdata     = $urandom;
      ext_in_valid  = is_in && (c == hs);
      ext_out_ready = !is_in && (c == hs);
      ext_in_data   = (is_in && (c == hs)) ? data : $urandom;
      #1;
      checkOutput("wait_stall", stall, 1);
      checkOutput("wait_in_ready", ext_in_ready, is_in);
      checkOutput("wait_out_valid", ext_out_valid, !is_in);
      if (!is_in) checkOutput("wait_out_data", ext_out_data, data);
      checkOutput("wait_rvalid", rdata_valid, 0);
      checkOutput("wait_last_out", last_out, exp_last);
    end

    if (timed_out) begin
      exp_err = 1'b1;
      if (is_in) exp_rdata = '0;
    end else begin
      if (is_in) exp_rdata = data;
      else exp_last = data;
    end

    @(posedge clock); #1;
    ext_in_valid  = 1'b0;
    ext_out_ready = 1'b0;
    #1;
    checkOutput("cmp_stall", stall, 0);
    checkOutput("cmp_rvalid", rdata_valid, is_in);
    if (is_in) checkOutput("cmp_rdata", cpu_rdata, exp_rdata);
    checkOutput("cmp_last_out", last_out, exp_last);
    checkOutput("cmp_io_error", io_error, exp_err);
    checkOutput("cmp_in_ready", ext_in_ready, 0);
    checkOutput("cmp_out_valid", ext_out_valid, 0);
    in_req  = 1'b0;
    out_req = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    reset   = 1'b1;
    in_req  = 1'b1;
    out_req = 1'b0;
    #1;
    checkOutput("rst_stall", stall, 0);
    @(posedge clock); #1;
    reset  = 1'b0;
    in_req = 1'b0;
    exp_rdata = '0;
    exp_last  = '0;
    exp_err   = 1'b0;
    #1;
    checkOutput("rst_rdata", cpu_rdata, 0);
    checkOutput("rst_last_out", last_out, 0);
    checkOutput("rst_out_data", ext_out_data, 0);
    checkOutput("rst_rvalid", rdata_valid, 0);
    checkOutput("rst_in_ready", ext_in_ready, 0);
    checkOutput("rst_out_valid", ext_out_valid, 0);
    checkOutput("rst_io_error", io_error, 0);
    checkOutput("rst_idle_stall", stall, 0);
  endtask

  initial begin
    int op;
    $display("[TB] start");
    repeat (2) @(posedge clock);
    doReset();

    // Immediate IN handshake, then a slow OUT sink.
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1);
    applyStimulus(1'b0, 1'b0, 32'h0000002A, 6);

    // OUT handshake landing exactly on the last wait cycle before timeout.
    applyStimulus(1'b0, 1'b0, 32'h12345678, T);

    // Simultaneous requests: IN wins, then back-to-back instant transfers.
    applyStimulus(1'b1, 1'b1, 32'hCAFEF00D, 1);
    applyStimulus(1'b0, 1'b0, 32'h00000011, 1);
    applyStimulus(1'b1, 1'b0, 32'h00000022, 1);
    applyStimulus(1'b0, 1'b0, 32'h00000033, 1);

    // Reset in the middle of an OUT wait.
    @(posedge clock); #1;
    out_req   = 1'b1;
    cpu_wdata = 32'h55AA55AA;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("mid_out_valid_pre", ext_out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_stall", stall, 0);
    @(posedge clock); #1;
    reset   = 1'b0;
    out_req = 1'b0;
    exp_rdata = '0;
    exp_last  = '0;
    exp_err   = 1'b0;
    #1;
    checkOutput("mid_out_valid", ext_out_valid, 0);
    checkOutput("mid_stall", stall, 0);
    checkOutput("mid_last_out", last_out, 0);
    checkOutput("mid_rvalid", rdata_valid, 0);
    applyStimulus(1'b1, 1'b0, 32'h0BADF00D, 2);

    // IN timeout, then the error stays sticky through good transfers.
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, NO_HS);
    applyStimulus(1'b0, 1'b0, 32'h00000077, 1);
    applyStimulus(1'b1, 1'b0, 32'h87654321, 3);
    applyStimulus(1'b0, 1'b0, 32'h99999999, NO_HS);

    // Randomized mix of operations and device latencies.
    doReset();
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      applyStimulus(op != 1, op == 2, $urandom, int'($urandom_range(1, T + 2)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #2;
        checkOutput("gap_stall", stall, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
